// File: rtl/rll_key_load_ctrl.sv
// rll_key_load_ctrl: loads a key from a byte stream, verifies its XOR
// checksum, and only then drives it onto a locked core's key inputs.
// Repeated checksum failures latch a lockout that only rst clears.
module rll_key_load_ctrl #(
  parameter int KEY_WIDTH  = 32,
  parameter int WORD_WIDTH = 8,
  parameter int MAX_FAIL   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  zeroize,
  input  logic                  kw_valid,
  input  logic [WORD_WIDTH-1:0] kw_data,
  output logic                  kw_ready,
  output logic [KEY_WIDTH-1:0]  key_out,
  output logic                  key_valid,
  output logic                  busy,
  output logic                  err,
  output logic                  locked
);

  localparam int NWORDS = KEY_WIDTH / WORD_WIDTH;
  localparam int CW     = $clog2(NWORDS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CHECK   = 3'd2,
    ACTIVE  = 3'd3,
    ERROR   = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [KEY_WIDTH-1:0]  shreg;
  logic [WORD_WIDTH-1:0] acc;
  logic [WORD_WIDTH-1:0] csum;
  logic [CW-1:0]         wcnt;
  logic [3:0]            fail_cnt;
  logic [3:0]            fail_next;
  logic                  xfer;
  logic                  is_csum_word;
  logic                  match;

  // Running XOR checksum step over one stream word.
  function automatic logic [WORD_WIDTH-1:0] xor_step(
    input logic [WORD_WIDTH-1:0] a,
    input logic [WORD_WIDTH-1:0] w
  );
    return a ^ w;
  endfunction

  // Stream handshake and checksum decode, all derived from registered state.
  always_comb begin
    xfer         = kw_valid && (state == LOAD);
    is_csum_word = (wcnt == CW'(NWORDS));
    match        = (acc == csum);
    fail_next    = fail_cnt + 4'd1;
  end

  // Next-state logic; zeroize outranks start, LOCKOUT is terminal.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (zeroize)    next_state = IDLE;
        else if (start) next_state = LOAD;
        else            next_state = IDLE;
      end
      LOAD: begin
        if (zeroize)                   next_state = IDLE;
        else if (xfer && is_csum_word) next_state = CHECK;
        else                           next_state = LOAD;
      end
      CHECK: begin
        if (zeroize)                        next_state = IDLE;
        else if (match)                     next_state = ACTIVE;
        else if (fail_next == 4'(MAX_FAIL)) next_state = LOCKOUT;
        else                                next_state = ERROR;
      end
      ACTIVE, ERROR: begin
        if (zeroize)    next_state = IDLE;
        else if (start) next_state = LOAD;
        else            next_state = state;
      end
      LOCKOUT: next_state = LOCKOUT;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Key assembly: shift words in MSB-first, accumulate XOR, capture checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      acc   <= '0;
      csum  <= '0;
      wcnt  <= '0;
    end else if (zeroize && state != LOCKOUT) begin
      shreg <= '0;
      acc   <= '0;
      csum  <= '0;
      wcnt  <= '0;
    end else if (next_state == LOAD && state != LOAD) begin
      shreg <= '0;
      acc   <= '0;
      csum  <= '0;
      wcnt  <= '0;
    end else if (xfer) begin
      if (is_csum_word) begin
        csum <= kw_data;
      end else begin
        shreg <= {shreg[KEY_WIDTH-WORD_WIDTH-1:0], kw_data};
        acc   <= xor_step(acc, kw_data);
        wcnt  <= wcnt + CW'(1);
      end
    end
  end

  // Consecutive-failure counter; cleared by a good check or rst only.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt <= 4'd0;
    end else if (state == CHECK && !zeroize) begin
      if (match) fail_cnt <= 4'd0;
      else       fail_cnt <= fail_next;
    end
  end

  // Key output: the verified key appears only while ACTIVE, zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_out <= '0;
    end else if (next_state == ACTIVE && state == CHECK) begin
      key_out <= shreg;
    end else if (next_state == ACTIVE) begin
      key_out <= key_out;
    end else begin
      key_out <= '0;
    end
  end

  // Status flags registered from the next state so they align with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      kw_ready  <= 1'b0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      locked    <= 1'b0;
    end else begin
      kw_ready  <= (next_state == LOAD);
      key_valid <= (next_state == ACTIVE);
      busy      <= (next_state == LOAD) || (next_state == CHECK);
      err       <= (next_state == ERROR) || (next_state == LOCKOUT);
      locked    <= (next_state == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_rll_key_load_ctrl.sv
// Directed bench for rll_key_load_ctrl: a per-cycle vector table plus
// hand-written backpressure and lockout sequences.
module tb_rll_key_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        zeroize;
  logic        kw_valid;
  logic [7:0]  kw_data;
  logic        kw_ready;
  logic [31:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;
  logic        locked;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        st;
    logic        zz;
    logic        v;
    logic [7:0]  d;
    logic [31:0] ko;
    logic        kv;
    logic        bz;
    logic        er;
    logic        lk;
    logic        rd;
  } vec_t;

  vec_t tbl[$];

  rll_key_load_ctrl #(.KEY_WIDTH(32), .WORD_WIDTH(8), .MAX_FAIL(3)) dut (
    .clk(clk), .rst(rst), .start(start), .zeroize(zeroize),
    .kw_valid(kw_valid), .kw_data(kw_data), .kw_ready(kw_ready),
    .key_out(key_out), .key_valid(key_valid), .busy(busy),
    .err(err), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic add(input logic st, input logic zz, input logic v, input logic [7:0] d,
                     input logic [31:0] ko, input logic kv, input logic bz,
                     input logic er, input logic lk, input logic rd);
    vec_t r;
    r.st = st; r.zz = zz; r.v = v; r.d = d;
    r.ko = ko; r.kv = kv; r.bz = bz; r.er = er; r.lk = lk; r.rd = rd;
    tbl.push_back(r);
  endtask

  // Drive inputs, take one rising edge, settle 1 time unit past it.
  task automatic cyc(input logic st, input logic zz, input logic v, input logic [7:0] d);
    start = st; zeroize = zz; kw_valid = v; kw_data = d;
    @(posedge clk);
    #1;
    start = 1'b0; zeroize = 1'b0; kw_valid = 1'b0; kw_data = 8'h00;
  endtask

  task automatic chk(input string name, input logic [31:0] ko, input logic kv,
                     input logic bz, input logic er, input logic lk, input logic rd);
    n_cmp++;
    if ({key_out, key_valid, busy, err, locked, kw_ready} !== {ko, kv, bz, er, lk, rd}) begin
      n_bad++;
      $display("FAIL %s: got ko=%h kv=%b busy=%b err=%b lk=%b rdy=%b, want ko=%h kv=%b busy=%b err=%b lk=%b rdy=%b",
               name, key_out, key_valid, busy, err, locked, kw_ready, ko, kv, bz, er, lk, rd);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // start, four key words, checksum, then one idle cycle for CHECK.
  task automatic run_load(input logic [31:0] key, input logic [7:0] cs);
    logic [31:0] k;
    k = key;
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, k[31:24]);
      k = k << 8;
    end
    cyc(1'b0, 1'b0, 1'b1, cs);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; zeroize = 1'b0; kw_valid = 1'b0; kw_data = 8'h00;

    //  st zz v  data    key_out       kv bz er lk rd
    // good key DEADBEEF, valid 2 cycles after checksum
    add(1, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hDE, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hAD, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hBE, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hEF, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h22, 32'h0,        0, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    add(0, 0, 1, 8'h55, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    // re-key: key cleared on the start edge, new key 00000001
    add(1, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h00, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h00, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h00, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h01, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h01, 32'h0,        0, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 32'h00000001, 1, 0, 0, 0, 0);
    // zeroize together with start: zeroize wins
    add(1, 1, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 1, 8'hFF, 32'h0,        0, 0, 0, 0, 0);
    // zeroize after two words, then a fresh load 01020304
    add(1, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h01, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h02, 32'h0,        0, 1, 0, 0, 1);
    add(0, 1, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h01, 32'h0,        0, 1, 0, 0, 1);
    add(1, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h02, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h03, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h04, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h04, 32'h0,        0, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 32'h01020304, 1, 0, 0, 0, 0);
    // bad checksum 23 -> ERROR, then retry with 22 -> ACTIVE
    add(1, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hDE, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hAD, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hBE, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hEF, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h23, 32'h0,        0, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 32'h0,        0, 0, 1, 0, 0);
    add(0, 0, 1, 8'h22, 32'h0,        0, 0, 1, 0, 0);
    add(1, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hDE, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hAD, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hBE, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'hEF, 32'h0,        0, 1, 0, 0, 1);
    add(0, 0, 1, 8'h22, 32'h0,        0, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 32'hDEADBEEF, 1, 0, 0, 0, 0);

    do_reset();
    chk("reset", 32'h0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].st, tbl[i].zz, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), tbl[i].ko, tbl[i].kv, tbl[i].bz, tbl[i].er, tbl[i].lk, tbl[i].rd);
    end

    // Backpressure: kw_valid low every other cycle with junk data on the bus.
    do_reset();
    begin
      logic [7:0] words [5];
      words[0] = 8'hDE; words[1] = 8'hAD; words[2] = 8'hBE; words[3] = 8'hEF; words[4] = 8'h22;
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("bp_start", 32'h0, 0, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
        cyc(1'b0, 1'b0, 1'b0, 8'hA5);
        chk($sformatf("bp_gap%0d", i), 32'h0, 0, 1, 0, 0, 1);
        cyc(1'b0, 1'b0, 1'b1, words[i]);
        if (i < 4) chk($sformatf("bp_word%0d", i), 32'h0, 0, 1, 0, 0, 1);
      end
      chk("bp_check", 32'h0, 0, 1, 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("bp_active", 32'hDEADBEEF, 1, 0, 0, 0, 0);
    end

    // Lockout after three consecutive checksum failures.
    do_reset();
    run_load(32'hDEADBEEF, 8'h00);
    chk("lock_fail1", 32'h0, 0, 0, 1, 0, 0);
    run_load(32'hDEADBEEF, 8'h00);
    chk("lock_fail2", 32'h0, 0, 0, 1, 0, 0);
    run_load(32'hDEADBEEF, 8'h00);
    chk("lock_fail3", 32'h0, 0, 0, 1, 1, 0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("lock_start_ignored", 32'h0, 0, 0, 1, 1, 0);
    run_load(32'hDEADBEEF, 8'h22);
    chk("lock_good_ignored", 32'h0, 0, 0, 1, 1, 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("lock_zeroize_ignored", 32'h0, 0, 0, 1, 1, 0);
    do_reset();
    chk("lock_reset", 32'h0, 0, 0, 0, 0, 0);
    run_load(32'hDEADBEEF, 8'h22);
    chk("post_lock_load", 32'hDEADBEEF, 1, 0, 0, 0, 0);

    // A good load in between resets the failure count.
    run_load(32'h01020304, 8'h00);
    chk("fc_fail1", 32'h0, 0, 0, 1, 0, 0);
    run_load(32'h01020304, 8'h00);
    chk("fc_fail2", 32'h0, 0, 0, 1, 0, 0);
    run_load(32'h01020304, 8'h04);
    chk("fc_good", 32'h01020304, 1, 0, 0, 0, 0);
    run_load(32'h01020304, 8'h00);
    chk("fc_fail_after_good", 32'h0, 0, 0, 1, 0, 0);

    // Reset mid-load: nothing partial survives.
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h12);
    cyc(1'b0, 1'b0, 1'b1, 8'h34);
    do_reset();
    chk("reset_midload", 32'h0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rll_key_load_ctrl.md
# rll_key_load_ctrl

Loads, checks and holds the 32-bit unlock key for a random-logic-locked combinational core, such as the 32-key-input RLL benchmark netlists. The key arrives as byte words over a valid/ready stream from secure storage, followed by one XOR checksum byte. The key is driven onto the core's key inputs only after the checksum matches. Until then, and after any failure, `key_out` is all-zero, so the locked core computes a corrupted function. Repeated checksum failures latch a lockout that only reset clears.

## Interface
Parameters:
- `KEY_WIDTH`, 32: key bits; must be a multiple of `WORD_WIDTH`.
- `WORD_WIDTH`, 8: stream word width.
- `MAX_FAIL`, 3: consecutive checksum failures that trigger LOCKOUT; range 1..15.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — one-cycle pulse that begins a key load.
- `zeroize`  in  1  — one-cycle pulse that clears the key immediately.
- `kw_valid`  in  1  — key-stream word valid.
- `kw_data`  in  `WORD_WIDTH`  — key-stream word.
- `kw_ready`  out  1  — controller accepts a word.
- `key_out`  out  `KEY_WIDTH`  — drives the core's key inputs; bit i goes to key input i.
- `key_valid`  out  1  — `key_out` holds a verified key.
- `busy`  out  1  — a load or check is in progress.
- `err`  out  1  — last load failed its checksum, or the block is locked out.
- `locked`  out  1  — lockout is latched.

## Operation
- States: IDLE, LOAD, CHECK, ACTIVE, ERROR, LOCKOUT.
- A transfer occurs when `kw_valid` and `kw_ready` are both high on a rising edge. `kw_ready` is high only in LOAD. `kw_valid` in any other state is ignored.
- Word order: N = `KEY_WIDTH`/`WORD_WIDTH` key words arrive first, most-significant first. The first word lands in `shreg[KEY_WIDTH-1 -: WORD_WIDTH]`. Transfer N+1 is the checksum word.
- Checksum: XOR of all N key words, accumulated as words arrive. The accumulator and word counter clear on entry to LOAD.
- State transitions:
  - IDLE → LOAD on `start`.
  - LOAD → CHECK on the checksum transfer.
  - CHECK (exactly 1 cycle): on match → ACTIVE, `shreg` loaded into `key_out`, `fail_cnt` cleared. On mismatch → `fail_cnt`+1, then ERROR, or LOCKOUT if `fail_cnt`+1 = `MAX_FAIL`.
  - ACTIVE → LOAD on `start` (re-key). `key_out` is cleared to 0 on the same edge.
  - ERROR → LOAD on `start`.
  - LOCKOUT is terminal until `rst`; `start` and `zeroize` are ignored.
- `zeroize` in IDLE, LOAD, CHECK, ACTIVE or ERROR moves to IDLE and clears `key_out`, `shreg`, the accumulator and the word counter. It does not clear `fail_cnt`.
- Priority within a cycle: `rst` > `zeroize` > `start` > stream transfer. A `start` seen during LOAD or CHECK is ignored.
- Output decode:
  - `key_out` is nonzero only in ACTIVE.
  - `key_valid` = (state == ACTIVE).
  - `busy` = LOAD or CHECK.
  - `err` = ERROR or LOCKOUT.
  - `locked` = LOCKOUT.
- Every output is registered or decoded directly from the state register. There is no combinational path from inputs to outputs except none: `kw_ready` comes from state only.

## Timing
- Reset values: state IDLE; `key_out` = 0, `key_valid` = 0, `busy` = 0, `err` = 0, `locked` = 0, `kw_ready` = 0, `fail_cnt` = 0.
- `start` sampled at edge E → `kw_ready` = 1 from E+1.
- With `kw_valid` held high, N+1 words transfer on N+1 consecutive edges.
- Checksum transfer at edge T → CHECK during cycle T+1 → `key_valid` (or `err`) high from edge T+2. Best-case load is N+3 cycles from `start`.
- `zeroize` at edge Z → `key_out` = 0 and `key_valid` = 0 from Z+1.
- Gaps in `kw_valid` stall LOAD indefinitely. There is no timeout; `zeroize` aborts the load.
- Reset mid-load: all state returns to reset values on the next edge. Partial key bits never reach `key_out`.

## Test plan
- Good key: `start`; stream DE, AD, BE, EF, then checksum 22 → `key_out` = 32'hDEADBEEF, `key_valid` = 1 exactly 2 cycles after the checksum transfer; `busy` = 0; `fail_cnt` = 0.
- Backpressure: same stream with `kw_valid` low every other cycle → identical result. `kw_ready` stays high throughout LOAD, and no word is captured when `kw_valid` = 0.
- Bad checksum: stream DE, AD, BE, EF, 23 → ERROR, `err` = 1, `key_out` = 0. A retry with 22 → ACTIVE, `err` = 0.
- Lockout: three consecutive loads ending in checksum 00 → after the third, `locked` = 1, `err` = 1. Then `start` plus a good stream → no `kw_ready`, `key_out` stays 0. After `rst` → IDLE, all outputs 0.
- Zeroize: in ACTIVE with key DEADBEEF, pulse `zeroize` together with `start` → next cycle IDLE (zeroize wins), `key_out` = 0. Zeroize after 2 of 4 words → IDLE. A fresh load of 01, 02, 03, 04, checksum 04 → `key_out` = 32'h01020304.
- Re-key: in ACTIVE, `start` → `key_out` = 0 on the next edge. A load of 00, 00, 00, 01, checksum 01 → `key_out` = 32'h00000001.
